// File: rtl/squeeze_scheduler_if.sv
// rtl/squeeze_scheduler_if.sv - squeeze scheduler handshake bundle (SQUEEZE_STALL_CNT_EN adds stall_cycles)
interface squeeze_scheduler_if #(
   parameter int CNT_W = 32
) ();
   logic             squeeze_start;
   logic [CNT_W-1:0] output_size;
   logic [1:0]       operation_mode;
   logic             perm_done;
   logic             output_buffer_available_wr;
   logic             last_output_block_clr;
   logic             perm_start;
   logic             output_buffer_we;
   logic             last_output_block;
   logic [CNT_W-1:0] output_size_q;
   logic [1:0]       operation_mode_q;
   logic             busy;
   logic             done;
`ifdef SQUEEZE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output squeeze_start, output_size, operation_mode, perm_done,
             output_buffer_available_wr, last_output_block_clr,
      input  perm_start, output_buffer_we, last_output_block, output_size_q,
             operation_mode_q, busy, done, stall_cycles
   );

   modport slave (
      input  squeeze_start, output_size, operation_mode, perm_done,
             output_buffer_available_wr, last_output_block_clr,
      output perm_start, output_buffer_we, last_output_block, output_size_q,
             operation_mode_q, busy, done, stall_cycles
   );
`else
   modport master (
      output squeeze_start, output_size, operation_mode, perm_done,
             output_buffer_available_wr, last_output_block_clr,
      input  perm_start, output_buffer_we, last_output_block, output_size_q,
             operation_mode_q, busy, done
   );

   modport slave (
      input  squeeze_start, output_size, operation_mode, perm_done,
             output_buffer_available_wr, last_output_block_clr,
      output perm_start, output_buffer_we, last_output_block, output_size_q,
             operation_mode_q, busy, done
   );
`endif
endinterface

// File: rtl/squeeze_scheduler.sv
// rtl/squeeze_scheduler.sv - SHAKE/SHA3 squeeze phase sequencer (optional macro SQUEEZE_STALL_CNT_EN)
module squeeze_scheduler #(
   parameter int RATE128_BYTES = 168,
   parameter int RATE256_BYTES = 136,
   parameter int RATE512_BYTES = 72,
   parameter int CNT_W         = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   squeeze_scheduler_if.slave io_bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BUF,
      S_WRITE,
      S_PERM,
      S_PERM_WAIT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_remaining;
   logic [CNT_W-1:0] r_size_q;
   logic [1:0]       r_mode_q;
   logic             r_last;

   logic [CNT_W-1:0] w_rate;
   logic [CNT_W-1:0] w_eff_len;
   logic             w_accept;
   logic             w_final;
   logic             w_we;
   logic             w_perm_start;
   logic             w_done;

   // Fixed-output SHA3 modes ignore the requested size; SHAKE uses it as given
   always_comb begin
      w_eff_len = io_bus.output_size;
      case (io_bus.operation_mode)
         2'd2:    w_eff_len = CNT_W'(32);
         2'd3:    w_eff_len = CNT_W'(64);
         default: w_eff_len = io_bus.output_size;
      endcase
   end

   // Rate of the job in flight, taken from the latched mode
   always_comb begin
      w_rate = CNT_W'(RATE512_BYTES);
      case (r_mode_q)
         2'd0:    w_rate = CNT_W'(RATE128_BYTES);
         2'd1:    w_rate = CNT_W'(RATE256_BYTES);
         2'd2:    w_rate = CNT_W'(RATE256_BYTES);
         default: w_rate = CNT_W'(RATE512_BYTES);
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && io_bus.squeeze_start;
   assign w_final  = (r_remaining <= w_rate);

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and per-state strobes
   always_comb begin
      w_next       = r_state;
      w_we         = 1'b0;
      w_perm_start = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.squeeze_start) begin
               w_next = (w_eff_len == '0) ? S_DONE : S_WAIT_BUF;
            end
         end
         S_WAIT_BUF: begin
            if (io_bus.output_buffer_available_wr) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            w_we   = 1'b1;
            w_next = w_final ? S_DONE : S_PERM;
         end
         S_PERM: begin
            w_perm_start = 1'b1;
            w_next       = S_PERM_WAIT;
         end
         S_PERM_WAIT: begin
            // Buffer-free is not consulted here: the dump stage may still be draining
            if (io_bus.perm_done) begin
               w_next = S_WAIT_BUF;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Job parameters latched on an accepted start; remaining drops one rate per non-final write
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_remaining <= '0;
         r_size_q    <= '0;
         r_mode_q    <= 2'd0;
      end else if (w_accept) begin
         r_remaining <= w_eff_len;
         r_size_q    <= w_eff_len;
         r_mode_q    <= io_bus.operation_mode;
      end else if ((r_state == S_WRITE) && !w_final) begin
         r_remaining <= r_remaining - w_rate;
      end
   end

   // Last-block flag: set by the final write, which takes priority over the dump-stage clear
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_last <= 1'b0;
      end else if ((r_state == S_WRITE) && w_final) begin
         r_last <= 1'b1;
      end else if (io_bus.last_output_block_clr) begin
         r_last <= 1'b0;
      end
   end

`ifdef SQUEEZE_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall;

   // Saturating count of cycles spent waiting on a busy output buffer
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_stall <= '0;
      end else if (w_accept) begin
         r_stall <= '0;
      end else if ((r_state == S_WAIT_BUF) && !io_bus.output_buffer_available_wr &&
                   (r_stall != {CNT_W{1'b1}})) begin
         r_stall <= r_stall + CNT_W'(1);
      end
   end

   assign io_bus.stall_cycles = r_stall;
`endif

   assign io_bus.perm_start        = w_perm_start;
   assign io_bus.output_buffer_we  = w_we;
   assign io_bus.done              = w_done;
   assign io_bus.busy              = (r_state != S_IDLE);
   assign io_bus.last_output_block = r_last;
   assign io_bus.output_size_q     = r_size_q;
   assign io_bus.operation_mode_q  = r_mode_q;

endmodule
